ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter that shares one resource among `N` requesters. Priority is held in a one-hot rotating pointer, which behaves like the team's ring counter but advances only when a grant completes. The block sits between the requesting units and the shared datapath. It issues a registered one-hot grant, holds that grant until the owner lets go, and caps ownership with a hold timeout.

## Interface
- `N`, 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, 8: maximum number of consecutive cycles one grant may last; must be ≥ 1.

- `clk`  in  1  system clock; all logic updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  N  request vector; bit i belongs to requester i.
- `release`  in  1  the current owner ends its grant; ignored in IDLE.
- `grant`  out  N  one-hot grant, or all zero; registered.
- `grant_valid`  out  1  equals OR of `grant`; registered.
- `owner_idx`  out  clog2(N)  index of the granted requester; holds its last value when idle.
- `ptr`  out  N  one-hot priority pointer; the set bit is the highest-priority requester.
- `timeout`  out  1  one-cycle pulse when a grant is force-ended by the hold limit.

## Operation
- The block has two states: IDLE and BUSY.
- Internal hold counter `hold_cnt` is clog2(MAX_HOLD+1) bits wide.
- Reset (`rst`=1 at an edge):
  - state=IDLE, `grant`=0, `grant_valid`=0, `owner_idx`=0, `ptr`=one-hot bit 0, `hold_cnt`=0, `timeout`=0.
  - Reset overrides all other inputs, including during BUSY.
- IDLE with `req`=0: outputs and state are unchanged, and `timeout` returns to 0.
- IDLE with `req`≠0 (arbitration):
  - Select the first set `req` bit in circular order starting at the `ptr` bit, then ptr+1 and onward, wrapping from N-1 to 0.
  - Next state BUSY; `grant`=one-hot of the selected bit; `owner_idx`=its index; `hold_cnt`=0.
- BUSY end conditions, checked at every edge:
  - (a) `release`=1;
  - (b) `req[owner_idx]`=0;
  - (c) `hold_cnt`==MAX_HOLD-1.
- BUSY when any end condition holds:
  - Next state IDLE; `grant`=0.
  - `ptr` rotates to the one-hot of owner_idx+1 mod N.
  - `timeout`=1 only if (c) holds and neither (a) nor (b) does; otherwise 0. A voluntary release takes precedence over a timeout.
- BUSY otherwise: `hold_cnt` increments by 1; grant is unchanged.
- Invariants:
  - `grant` is never multi-hot.
  - `grant` never changes while BUSY.
  - `ptr` is always exactly one-hot.
  - `ptr` changes only on BUSY→IDLE.
- `req` bits other than the owner's are ignored while BUSY.

## Timing
- Grant latency: a request sampled in IDLE at edge k produces `grant` visible from edge k to edge k+1. Latency is one cycle.
- Grant duration: from 1 to MAX_HOLD cycles.
- An end condition sampled at edge k clears `grant` after edge k.
- Turnaround: at least one cycle with `grant`=0 between consecutive grants. Sustained throughput is therefore one grant per 2 cycles at best.
- `timeout` is high for exactly the first IDLE cycle following a forced end.
- Reset mid-BUSY: `grant` drops after the reset edge, `ptr` returns to bit 0, and no `timeout` is asserted.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=1111 → `grant`=0000, `grant_valid`=0, `ptr`=0001, `timeout`=0 throughout.
- Single requester: `req`=0010, then `release` pulsed in the grant's second cycle → `grant`=0010 and `owner_idx`=1 one cycle after the request. `grant`=0000 after the release edge, and `ptr`=0100.
- Fairness: `req`=1111 held, `release`=1 every cycle → `grant` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; `ptr` steps 0010, 0100, 1000, 0001.
- Wrap-around priority, with `ptr`=0100 after a grant to requester 1:
  - `req`=0011 → `grant`=0001 (search order 2, 3, 0).
  - then `req`=0110 → `grant`=0100.
- Timeout with MAX_HOLD=8: `req`=1000 held, `release`=0 → `grant`=1000 for exactly 8 cycles, then `grant`=0000 with `timeout`=1 for one cycle, and `ptr`=0001. The same run with `release`=1 on the 8th cycle → `timeout` stays 0.
- Request withdrawal and reset mid-BUSY:
  - `req`=0100 granted, then `req`=0000 → grant clears one edge later with `timeout`=0 and `ptr`=1000.
  - `rst` asserted on the 3rd BUSY cycle → `grant`=0 and `ptr`=0001 on the next cycle.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer, registered one-hot grant
// and a hold-time limit that force-ends long grants.
module ring_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               req_i,
  input  logic                       release_i,
  output logic [N-1:0]               grant_o,
  output logic                       grant_valid_o,
  output logic [$clog2(N)-1:0]       owner_idx_o,
  output logic [N-1:0]               ptr_o,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] OneHot0 = N'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              gvalid_q, gvalid_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [IdxW-1:0]   ptr_idx;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   nxt_idx;
  logic              found;
  int unsigned       cand;
  logic              end_rel, end_wd, end_to;

  // Circular search starting at the pointer position; the first hit wins.
  always_comb begin
    ptr_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IdxW'(i);
    end
    found   = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_idx) + k) % N;
      if (!found && req_i[IdxW'(cand)]) begin
        found   = 1'b1;
        sel_idx = IdxW'(cand);
      end
    end
  end

  assign nxt_idx = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign end_rel = release_i;
  assign end_wd  = !req_i[owner_q];
  assign end_to  = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gvalid_d  = gvalid_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StBusy;
          grant_d  = OneHot0 << sel_idx;
          gvalid_d = 1'b1;
          owner_d  = sel_idx;
          cnt_d    = '0;
        end
      end
      StBusy: begin
        if (end_rel || end_wd || end_to) begin
          state_d   = StIdle;
          grant_d   = '0;
          gvalid_d  = 1'b0;
          ptr_d     = OneHot0 << nxt_idx;
          // Voluntary release or withdrawal masks a coincident timeout.
          timeout_d = end_to && !end_rel && !end_wd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gvalid_q  <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= OneHot0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gvalid_q  <= gvalid_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = gvalid_q;
  assign owner_idx_o   = owner_q;
  assign ptr_o         = ptr_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter: a behavioural model queues expected outputs per cycle.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   owner_idx;
  logic [N-1:0] ptr;
  logic         timeout;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .release_i     (rel),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .owner_idx_o   (owner_idx),
    .ptr_o         (ptr),
    .timeout_o     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int grant;
    int gv;
    int own;
    int ptr;
    int to;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit m_busy;
  int m_ptr, m_own, m_cnt, m_to, m_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model(input logic [N-1:0] r, input logic rl, input logic rs);
    bit a, b, c;
    if (rs) begin
      m_busy = 0; m_grant = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_busy && r[j]) begin
          m_busy = 1; m_own = j; m_cnt = 0; m_grant = 1 << j;
        end
      end
    end else begin
      a = rl;
      b = !r[m_own];
      c = (m_cnt == MAX_HOLD - 1);
      if (a || b || c) begin
        m_busy  = 0;
        m_grant = 0;
        m_ptr   = (m_own + 1) % N;
        m_to    = (c && !a && !b) ? 1 : 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rl, input logic rs);
    exp_t e;
    req = r;
    rel = rl;
    rst = rs;
    model(r, rl, rs);
    e.grant = m_grant;
    e.gv    = (m_grant != 0) ? 1 : 0;
    e.own   = m_own;
    e.ptr   = 1 << m_ptr;
    e.to    = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("grant_valid", 32'(grant_valid), 32'(e.gv));
      check("owner_idx", 32'(owner_idx), 32'(e.own));
      check("ptr", 32'(ptr), 32'(e.ptr));
      check("timeout", 32'(timeout), 32'(e.to));
    end
  endtask

  int fair_exp[9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
  int hold_cycles;

  initial begin
    req = '0;
    rel = 1'b0;
    rst = 1'b1;

    // Reset with all requests active
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h1);

    // Single requester
    step(4'b0010, 1'b0, 1'b0);
    check("single_grant", 32'(grant), 32'h2);
    check("single_owner", 32'(owner_idx), 32'd1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    check("single_clear", 32'(grant), 32'h0);
    check("single_ptr", 32'(ptr), 32'h4);
    step(4'b0000, 1'b0, 1'b0);

    // Fairness
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      check("fair_seq", 32'(grant), 32'(fair_exp[i]));
    end

    // Wrap-around: ptr at 2, requests 0 and 1
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    check("wrap_0011", 32'(grant), 32'h1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    check("wrap_0110", 32'(grant), 32'h4);

    // Forced timeout
    step(4'b0000, 1'b0, 1'b1);
    hold_cycles = 0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b1000, 1'b0, 1'b0);
      if (grant == 4'b1000) hold_cycles++;
    end
    check("hold_cycles", 32'(hold_cycles), 32'(MAX_HOLD));
    step(4'b1000, 1'b0, 1'b0);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_ptr", 32'(ptr), 32'h1);
    step(4'b0000, 1'b0, 1'b0);
    check("to_drop", 32'(timeout), 32'd0);

    // Release on the last permitted cycle masks the timeout
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    check("rel_no_to", 32'(timeout), 32'd0);

    // Withdrawal, then reset mid-grant
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("wd_grant", 32'(grant), 32'h0);
    check("wd_ptr", 32'(ptr), 32'h8);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    check("rst_busy_grant", 32'(grant), 32'h0);
    check("rst_busy_ptr", 32'(ptr), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
